// File: rtl/axi_rd_if.sv
// AXI read-channel bundle (AR + R) shared by the read responder and its masters.
interface axi_rd_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_rd_responder.sv
// Single-outstanding AXI read responder returning each beat's byte address as data.
// Optional burst legality checking (SLVERR) is enabled by defining AXI_RD_RESP_ERR_CHECK_EN.
module axi_rd_responder #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input logic     aclk,
  input logic     aresetn,
  axi_rd_if.slave axi
);

  typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

  state_t            state_q, state_d;
  logic              active_q;
  logic [3:0]        lat_q;
  logic [7:0]        beat_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wrap_lo_q;
  logic [ADDR_W-1:0] wrap_hi_q;

  logic              ar_hs;
  logic              r_hs;
  logic              last_beat;
  logic [ADDR_W-1:0] size_bytes;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] t_bytes;
  logic [ADDR_W-1:0] cap_lo;

  assign ar_hs     = axi.arvalid && axi.arready;
  assign r_hs      = axi.rvalid && axi.rready;
  assign last_beat = (beat_q == len_q);

  // Wrap window is computed once at AR acceptance; beats only compare against it.
  assign t_bytes = (ADDR_W'(axi.arlen) + ADDR_W'(1)) << axi.arsize;
  assign cap_lo  = axi.araddr & ~(t_bytes - ADDR_W'(1));

  always_comb begin
    size_bytes = ADDR_W'(1) << size_q;
    incr_addr  = (addr_q & ~(size_bytes - ADDR_W'(1))) + size_bytes;
    next_addr  = incr_addr;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (incr_addr == wrap_hi_q) ? wrap_lo_q : incr_addr;
      default: next_addr = incr_addr;
    endcase
  end

`ifdef AXI_RD_RESP_ERR_CHECK_EN
  logic              err_q;
  logic              err_d;
  logic [ADDR_W-1:0] cap_size;
  logic [ADDR_W-1:0] cap_align;
  logic [16:0]       end_off;

  always_comb begin
    cap_size  = ADDR_W'(1) << axi.arsize;
    cap_align = axi.araddr & ~(cap_size - ADDR_W'(1));
    // Offset of the last byte within the start 4 KB page; any carry past bit 11 crosses.
    end_off   = 17'(cap_align[11:0]) + 17'(t_bytes) - 17'd1;
    err_d     = (axi.arsize > 3'($clog2(DATA_W/8)))
             || (axi.arburst == 2'b10 && !(axi.arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
             || (axi.arburst == 2'b11)
             || (axi.arburst == 2'b01 && (|end_off[16:12]));
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      err_q <= 1'b0;
    else if (state_q == IDLE && ar_hs)
      err_q <= err_d;
  end

  assign axi.rresp = (state_q == DATA && err_q) ? 2'b10 : 2'b00;
`else
  assign axi.rresp = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ar_hs) state_d = (RD_LAT == 0) ? DATA : WAIT;
      WAIT: if (lat_q == '0) state_d = DATA;
      DATA: if (r_hs && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      active_q  <= 1'b0;
      lat_q     <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      id_q      <= '0;
      addr_q    <= '0;
      wrap_lo_q <= '0;
      wrap_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      case (state_q)
        IDLE: if (ar_hs) begin
          id_q      <= axi.arid;
          addr_q    <= axi.araddr;
          len_q     <= axi.arlen;
          size_q    <= axi.arsize;
          burst_q   <= axi.arburst;
          wrap_lo_q <= cap_lo;
          wrap_hi_q <= cap_lo + t_bytes;
          beat_q    <= '0;
          lat_q     <= 4'((RD_LAT == 0) ? 0 : RD_LAT - 1);
        end
        WAIT: if (lat_q != '0) lat_q <= lat_q - 4'd1;
        DATA: if (r_hs) begin
          if (last_beat) begin
            beat_q <= '0;
          end else begin
            beat_q <= beat_q + 8'd1;
            addr_q <= next_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // arready is held low until the first clock edge after reset release.
  assign axi.arready = active_q && (state_q == IDLE);
  assign axi.rvalid  = (state_q == DATA);
  assign axi.rlast   = (state_q == DATA) && last_beat;
  assign axi.rid     = id_q;
  assign axi.rdata   = DATA_W'(addr_q);

endmodule

// File: tb/tb_axi_rd_responder.sv
// Directed bench for axi_rd_responder: table of bursts plus backpressure, reset and back-to-back sequences.
module tb_axi_rd_responder;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int RD_LAT = 2;
`ifdef AXI_RD_RESP_ERR_CHECK_EN
  localparam logic [1:0] ERR_RESP = 2'b10;
`else
  localparam logic [1:0] ERR_RESP = 2'b00;
`endif

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  axi_rd_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_rd_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi     (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]       id;
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             illegal;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst, input logic illegal,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst; v.illegal = illegal;
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    chk("arready_idle", 64'(bus.arready), 64'h1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!bus.rvalid && n < 40) begin
      chk("arready_wait", 64'(bus.arready), 64'h0);
      @(posedge aclk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(RD_LAT));
  endtask

  task automatic run_vec(input vec_t v);
    issue_ar(v.id, v.addr, v.len, v.size, v.burst);
    wait_rvalid();
    for (int b = 0; b <= int'(v.len); b++) begin
      chk("rvalid", 64'(bus.rvalid), 64'h1);
      chk("rid", 64'(bus.rid), 64'(v.id));
      chk("rdata", bus.rdata, 64'(v.exp[b]));
      chk("rresp", 64'(bus.rresp), 64'(v.illegal ? ERR_RESP : 2'b00));
      chk("rlast", 64'(bus.rlast), 64'(b == int'(v.len)));
      chk("arready_data", 64'(bus.arready), 64'h0);
      @(posedge aclk); #1;
    end
    chk("rvalid_end", 64'(bus.rvalid), 64'h0);
    chk("arready_end", 64'(bus.arready), 64'h1);
  endtask

  initial begin
    int beat;
    int cyc;
    int seen;

    vecs[0] = mk(4'd5, 32'h1000, 8'd3, 3'd2, 2'b01, 1'b0, 32'h1000, 32'h1004, 32'h1008, 32'h100C);
    vecs[1] = mk(4'd3, 32'h2038, 8'd3, 3'd3, 2'b10, 1'b0, 32'h2038, 32'h2020, 32'h2028, 32'h2030);
    vecs[2] = mk(4'd1, 32'h0040, 8'd2, 3'd2, 2'b00, 1'b0, 32'h0040, 32'h0040, 32'h0040, 32'h0);
    vecs[3] = mk(4'd2, 32'h0FFC, 8'd1, 3'd2, 2'b01, 1'b1, 32'h0FFC, 32'h1000, 32'h0, 32'h0);
    vecs[4] = mk(4'd6, 32'h1003, 8'd2, 3'd2, 2'b01, 1'b0, 32'h1003, 32'h1004, 32'h1008, 32'h0);
    vecs[5] = mk(4'd7, 32'h0014, 8'd1, 3'd2, 2'b10, 1'b0, 32'h0014, 32'h0010, 32'h0, 32'h0);
    vecs[6] = mk(4'd8, 32'h0100, 8'd1, 3'd2, 2'b11, 1'b1, 32'h0100, 32'h0104, 32'h0, 32'h0);
    vecs[7] = mk(4'd9, 32'h0000, 8'd2, 3'd2, 2'b10, 1'b1, 32'h0000, 32'h0004, 32'h0008, 32'h0);
    vecs[8] = mk(4'hA, 32'h0000, 8'd1, 3'd4, 2'b01, 1'b1, 32'h0000, 32'h0010, 32'h0, 32'h0);
    vecs[9] = mk(4'hF, 32'h0500, 8'd0, 3'd2, 2'b01, 1'b0, 32'h0500, 32'h0, 32'h0, 32'h0);

    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.arsize = '0; bus.arburst = '0; bus.rready = 1'b0;
    aresetn = 1'b0;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_arready", 64'(bus.arready), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst_rlast", 64'(bus.rlast), 64'h0);
    chk("rst_rresp", 64'(bus.rresp), 64'h0);
    chk("rst_rid", 64'(bus.rid), 64'h0);
    chk("rst_rdata", bus.rdata, 64'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    chk("arready_before_edge", 64'(bus.arready), 64'h0);
    @(posedge aclk); #1;
    chk("arready_after_edge", 64'(bus.arready), 64'h1);

    bus.rready = 1'b1;
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // FIXED burst with rready pattern 1,0,0,1,1
    issue_ar(4'd1, 32'h40, 8'd2, 3'd2, 2'b00);
    wait_rvalid();
    beat = 0;
    cyc = 0;
    while (beat <= 2 && cyc < 20) begin
      bus.rready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
      chk("bp_rvalid", 64'(bus.rvalid), 64'h1);
      chk("bp_rdata", bus.rdata, 64'h40);
      chk("bp_rid", 64'(bus.rid), 64'h1);
      chk("bp_rresp", 64'(bus.rresp), 64'h0);
      chk("bp_rlast", 64'(bus.rlast), 64'(beat == 2));
      chk("bp_arready", 64'(bus.arready), 64'h0);
      @(posedge aclk);
      if (bus.rready) beat++;
      #1;
      cyc++;
    end
    chk("bp_cycles", 64'(cyc), 64'd5);
    chk("bp_rvalid_end", 64'(bus.rvalid), 64'h0);
    bus.rready = 1'b1;

    // Reset during the second beat of an 8-beat burst
    issue_ar(4'd7, 32'h3000, 8'd7, 3'd2, 2'b01);
    wait_rvalid();
    chk("mid_beat0", bus.rdata, 64'h3000);
    @(posedge aclk); #1;
    chk("mid_beat1", bus.rdata, 64'h3004);
    aresetn = 1'b0;
    #1;
    chk("mid_rvalid", 64'(bus.rvalid), 64'h0);
    chk("mid_arready", 64'(bus.arready), 64'h0);
    chk("mid_rlast", 64'(bus.rlast), 64'h0);
    chk("mid_rid", 64'(bus.rid), 64'h0);
    chk("mid_rdata", bus.rdata, 64'h0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("mid_arready_rel", 64'(bus.arready), 64'h1);
    seen = 0;
    repeat (5) begin
      if (bus.rvalid) seen++;
      @(posedge aclk); #1;
    end
    chk("mid_no_residual", 64'(seen), 64'h0);
    chk("mid_arready_idle", 64'(bus.arready), 64'h1);

    // Back-to-back requests with arvalid held high
    bus.arid = 4'd4; bus.araddr = 32'h600; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.arvalid = 1'b1;
    chk("b2b_arready_a", 64'(bus.arready), 64'h1);
    @(posedge aclk); #1;
    bus.arid = 4'd9; bus.araddr = 32'h700; bus.arlen = 8'd1;
    chk("b2b_arready_busy", 64'(bus.arready), 64'h0);
    wait_rvalid();
    chk("b2b_a_rdata", bus.rdata, 64'h600);
    chk("b2b_a_rid", 64'(bus.rid), 64'h4);
    chk("b2b_a_rlast", 64'(bus.rlast), 64'h1);
    @(posedge aclk); #1;
    chk("b2b_arready_gap", 64'(bus.arready), 64'h1);
    chk("b2b_rvalid_gap", 64'(bus.rvalid), 64'h0);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
    chk("b2b_arready_b", 64'(bus.arready), 64'h0);
    wait_rvalid();
    chk("b2b_b0_rdata", bus.rdata, 64'h700);
    chk("b2b_b0_rid", 64'(bus.rid), 64'h9);
    chk("b2b_b0_rlast", 64'(bus.rlast), 64'h0);
    @(posedge aclk); #1;
    chk("b2b_b1_rdata", bus.rdata, 64'h704);
    chk("b2b_b1_rlast", 64'(bus.rlast), 64'h1);
    @(posedge aclk); #1;
    chk("b2b_rvalid_end", 64'(bus.rvalid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
